// File: rtl/nn_frame_sequencer.sv
// Frame sequencer: gathers an input byte frame, steps an external compute
// pipeline through NUM_STAGES stages, then streams the final result out byte-wise.
module nn_frame_sequencer #(
    parameter int unsigned IN_BYTES    = 256,
    parameter int unsigned OUT_BYTES   = 10,
    parameter int unsigned NUM_STAGES  = 9,
    parameter int unsigned TIMEOUT_CYC = 100000,
    localparam int unsigned SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk_100MHz,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic [IN_BYTES*8-1:0] in_vector,
    output logic                  stage_start,
    output logic [SW-1:0]         stage_idx,
    input  logic                  stage_done,
    input  logic [OUT_BYTES*8-1:0] result,
    output logic [7:0]            tx_data,
    output logic                  tx_enable,
    input  logic                  tx_busy,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int unsigned IW = $clog2(IN_BYTES + 1);
    localparam int unsigned OW = $clog2(OUT_BYTES + 1);
    localparam int unsigned GW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [IW-1:0] IN_LAST    = IW'(IN_BYTES - 1);
    localparam logic [OW-1:0] OUT_END    = OW'(OUT_BYTES);
    localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_STAGES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        RECV,
        LAUNCH,
        WAIT,
        SEND,
        SEND_WAIT
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IW-1:0]          in_cnt;
    logic [OW-1:0]          out_cnt;
    logic [GW-1:0]          gap_cnt;
    logic [OUT_BYTES*8-1:0] outbuf;
    logic                   seen_busy;
    logic                   stage_start_nxt;
    logic                   tx_enable_nxt;

    logic capture;
    logic last_in;
    logic last_stage;
    logic timeout;

    assign capture    = (state == RECV) && rx_valid;
    assign last_in    = (in_cnt == IN_LAST);
    assign last_stage = (stage_idx == STAGE_LAST);
    // Timeout fires on the idle cycle that would bring the gap count to TIMEOUT_CYC.
    assign timeout    = (TIMEOUT_CYC != 0) && (state == RECV) && !rx_valid &&
                        (in_cnt != '0) && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state <= RECV;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RECV: begin
                if (rx_valid && last_in) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (stage_done) begin
                    state_nxt = last_stage ? SEND : LAUNCH;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    state_nxt = SEND_WAIT;
                end
            end
            SEND_WAIT: begin
                if (seen_busy && !tx_busy) begin
                    state_nxt = (out_cnt == OUT_END) ? RECV : SEND;
                end
            end
            default: begin
                state_nxt = RECV;
            end
        endcase
    end

    always_comb begin
        busy            = (state != RECV);
        stage_start_nxt = (state == LAUNCH);
        tx_enable_nxt   = (state == SEND) && !tx_busy;
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            in_vector   <= '0;
            in_cnt      <= '0;
            gap_cnt     <= '0;
            frame_err   <= 1'b0;
            stage_idx   <= '0;
            stage_start <= 1'b0;
            outbuf      <= '0;
            out_cnt     <= '0;
            tx_data     <= '0;
            tx_enable   <= 1'b0;
            seen_busy   <= 1'b0;
        end else begin
            stage_start <= stage_start_nxt;
            tx_enable   <= tx_enable_nxt;

            if (capture) begin
                in_vector[{in_cnt, 3'b000} +: 8] <= rx_data;
                in_cnt  <= last_in ? '0 : in_cnt + 1'b1;
                gap_cnt <= '0;
                if (in_cnt == '0) begin
                    frame_err <= 1'b0;
                end
                if (last_in) begin
                    stage_idx <= '0;
                end
            end else if (timeout) begin
                in_cnt    <= '0;
                gap_cnt   <= '0;
                frame_err <= 1'b1;
            end else if ((state == RECV) && (in_cnt != '0)) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end

            if (rx_valid && (state != RECV)) begin
                frame_err <= 1'b1;
            end

            if ((state == WAIT) && stage_done) begin
                if (last_stage) begin
                    outbuf  <= result;
                    out_cnt <= '0;
                end else begin
                    stage_idx <= stage_idx + 1'b1;
                end
            end

            if (tx_enable_nxt) begin
                tx_data   <= outbuf[{out_cnt, 3'b000} +: 8];
                out_cnt   <= out_cnt + 1'b1;
                seen_busy <= 1'b0;
            end else if ((state == SEND_WAIT) && tx_busy) begin
                seen_busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nn_frame_sequencer.sv
// Directed bench for nn_frame_sequencer with a small stage model and
// transmitter model; small frame sizes keep every scenario short.
module tb_nn_frame_sequencer;

    localparam int unsigned IN_BYTES    = 4;
    localparam int unsigned OUT_BYTES   = 2;
    localparam int unsigned NUM_STAGES  = 3;
    localparam int unsigned TIMEOUT_CYC = 20;

    logic        clk_100MHz = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] in_vector;
    logic        stage_start;
    logic [1:0]  stage_idx;
    logic        stage_done_m;
    logic        stray_done;
    logic [15:0] result;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_busy;
    logic        busy;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;

    int         stage_log[$];
    logic [7:0] tx_log[$];
    int         tx_viol = 0;
    int         tx_hold = 3;
    int         tx_left;
    int         st_left;

    always #5 clk_100MHz = ~clk_100MHz;

    nn_frame_sequencer #(
        .IN_BYTES   (IN_BYTES),
        .OUT_BYTES  (OUT_BYTES),
        .NUM_STAGES (NUM_STAGES),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .in_vector  (in_vector),
        .stage_start(stage_start),
        .stage_idx  (stage_idx),
        .stage_done (stage_done_m | stray_done),
        .result     (result),
        .tx_data    (tx_data),
        .tx_enable  (tx_enable),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_100MHz);
        #1;
    endtask

    // Stage model: completion pulse 5 cycles after each observed start.
    initial begin
        stage_done_m = 1'b0;
        st_left      = 0;
        forever begin
            tick;
            stage_done_m = 1'b0;
            if (stage_start) begin
                stage_log.push_back(int'(stage_idx));
                st_left = 5;
            end else if (st_left > 0) begin
                st_left--;
                if (st_left == 0) stage_done_m = 1'b1;
            end
        end
    end

    // Transmitter model: busy for tx_hold cycles after each request.
    initial begin
        tx_busy = 1'b0;
        tx_left = 0;
        forever begin
            tick;
            if (tx_enable) begin
                if (tx_busy) tx_viol++;
                tx_log.push_back(tx_data);
                tx_left = tx_hold;
                tx_busy = 1'b1;
            end else if (tx_left > 0) begin
                tx_left--;
                if (tx_left == 0) tx_busy = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            send_byte(v[8*i +: 8]);
        end
    endtask

    task automatic clear_logs;
        stage_log.delete();
        tx_log.delete();
        tx_viol = 0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            tick;
            if (!busy) ok = 1'b1;
        end
        chk({tag, "_idle"}, ok, 1);
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_nstages"}, stage_log.size(), 3);
        if (stage_log.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk({tag, "_stage_idx"}, stage_log[i], i);
            end
        end
        chk({tag, "_ntx"}, tx_log.size(), 2);
        if (tx_log.size() == 2) begin
            chk({tag, "_tx0"}, tx_log[0], 8'hEF);
            chk({tag, "_tx1"}, tx_log[1], 8'hBE);
        end
        chk({tag, "_tx_while_busy"}, tx_viol, 0);
        chk({tag, "_busy_end"}, busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ferr"}, frame_err, 0);
        chk({tag, "_start"}, stage_start, 0);
        chk({tag, "_txen"}, tx_enable, 0);
        chk({tag, "_txdata"}, tx_data, 0);
        chk({tag, "_invec"}, in_vector, 0);
        chk({tag, "_idx"}, stage_idx, 0);
    endtask

    // Frame 01..04 with cycle-exact stage_start latency checks.
    task automatic latency_frame(input string tag);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        chk({tag, "_start_t"}, stage_start, 0);
        chk({tag, "_busy_launch"}, busy, 1);
        tick;
        chk({tag, "_start_t1"}, stage_start, 1);
        chk({tag, "_idx_first"}, stage_idx, 0);
        tick;
        chk({tag, "_start_t2"}, stage_start, 0);
        chk({tag, "_vec"}, in_vector, 32'h04030201);
        wait_idle(tag);
        check_results(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        rst_n      = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        stray_done = 1'b0;
        result     = 16'hBEEF;
        repeat (3) tick;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick;

        clear_logs();
        latency_frame("f1");
        chk("f1_ferr", frame_err, 0);

        stray_done = 1'b1;
        tick;
        stray_done = 1'b0;
        chk("stray_done_busy", busy, 0);
        tick;
        chk("stray_done_start", stage_start, 0);
        chk("stray_done_idx", stage_idx, 2);
        chk("stray_done_ferr", frame_err, 0);

        tx_hold = 30;
        clear_logs();
        send_frame(32'h44332211);
        tick;
        tick;
        send_byte(8'h99);
        chk("wait_rx_ferr", frame_err, 1);
        chk("wait_rx_vec", in_vector, 32'h44332211);
        chk("wait_rx_busy", busy, 1);
        wait_idle("f2");
        check_results("f2");
        chk("f2_ferr_sticky", frame_err, 1);

        tx_hold = 3;
        clear_logs();
        send_byte(8'hAA);
        chk("ferr_clear1", frame_err, 0);
        send_byte(8'hBB);
        repeat (19) tick;
        chk("gap19_ferr", frame_err, 0);
        tick;
        chk("gap20_ferr", frame_err, 1);
        chk("gap20_busy", busy, 0);
        send_byte(8'hC1);
        chk("ferr_clear2", frame_err, 0);
        send_byte(8'hC2);
        send_byte(8'hC3);
        send_byte(8'hC4);
        chk("timeout_vec", in_vector, 32'hC4C3C2C1);
        wait_idle("f3");
        check_results("f3");

        tx_hold = 30;
        clear_logs();
        send_frame(32'h08070605);
        tick;
        tick;
        send_byte(8'h77);
        seen = 1'b0;
        for (int n = 0; n < 500 && !seen; n++) begin
            tick;
            if (tx_enable) seen = 1'b1;
        end
        chk("rst_tx1_seen", seen, 1);
        repeat (31) tick;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_ferr", frame_err, 1);
        chk("pre_rst_txdata", tx_data, 8'hEF);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        tx_hold = 3;
        clear_logs();
        latency_frame("f4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
